// File: rtl/alu32_rr_arbiter.sv
// alu32_rr_arbiter: round-robin arbiter/sequencer sharing one ALU32 among N_REQ requesters.
// Flow: IDLE -> GRANT (one-cycle alu_start) -> BUSY (hold grant until alu_done) -> IDLE.
// Optional build macro ALU32_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts the
// grant after TIMEOUT cycles without alu_done and pulses err for one cycle.
// Handshake: a request is a level on req; once granted, the operation runs
// to alu_done regardless of req, and alu_done is only honoured in BUSY.
module alu32_rr_arbiter #(
  parameter int N_REQ   = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             alu_done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             alu_start,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  // Reject configurations the index/counter widths cannot represent.
  if (N_REQ < 2 || N_REQ > 8 || (1 << IDX_W) < N_REQ ||
      TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_param_check
    $error("alu32_rr_arbiter: illegal parameter combination");
  end

  state_t           state, state_n;
  logic [IDX_W-1:0] last_idx, last_idx_n;
  logic [IDX_W-1:0] gnt_idx_n;
  logic [N_REQ-1:0] gnt_n;
  logic             gnt_valid_n, alu_start_n, busy_n, err_n;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;

`ifdef ALU32_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt, to_cnt_n;
`endif

  // Round-robin pick: first set req bit scanning upward from last_idx+1 with wrap.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      int cand;
      cand = int'(last_idx) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n     = state;
    last_idx_n  = last_idx;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    alu_start_n = 1'b0;
    busy_n      = busy;
    err_n       = 1'b0;
`ifdef ALU32_ARB_TIMEOUT_EN
    to_cnt_n    = to_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_n     = S_GRANT;
          last_idx_n  = win_idx;
          gnt_n       = N_REQ'(1) << win_idx;
          gnt_idx_n   = win_idx;
          gnt_valid_n = 1'b1;
          alu_start_n = 1'b1;
          busy_n      = 1'b1;
        end
      end
      S_GRANT: begin
        // alu_done is deliberately ignored while the start pulse is out.
        state_n = S_BUSY;
`ifdef ALU32_ARB_TIMEOUT_EN
        to_cnt_n = '0;
`endif
      end
      S_BUSY: begin
        if (alu_done) begin
          state_n     = S_IDLE;
          gnt_n       = '0;
          gnt_idx_n   = '0;
          gnt_valid_n = 1'b0;
          busy_n      = 1'b0;
        end
`ifdef ALU32_ARB_TIMEOUT_EN
        // Done in the same cycle as expiry takes the normal completion path.
        else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n     = S_IDLE;
          gnt_n       = '0;
          gnt_idx_n   = '0;
          gnt_valid_n = 1'b0;
          busy_n      = 1'b0;
          err_n       = 1'b1;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_n     = S_IDLE;
        gnt_n       = '0;
        gnt_idx_n   = '0;
        gnt_valid_n = 1'b0;
        busy_n      = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers; reset gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_idx  <= IDX_W'(N_REQ - 1);
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      alu_start <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      last_idx  <= last_idx_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
      alu_start <= alu_start_n;
      busy      <= busy_n;
      err       <= err_n;
    end
  end

`ifdef ALU32_ARB_TIMEOUT_EN
  // BUSY watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt <= '0;
    else        to_cnt <= to_cnt_n;
  end
`endif

endmodule
